// File: rtl/eth_tx_framer.sv
// Ethernet TX framer: buffers one payload, then streams dst/src/type/payload/pad to the MAC byte port.
// Optional 802.1Q tag insertion when ETH_TX_VLAN_EN is defined.
module eth_tx_framer #(
  parameter int MAX_PAYLOAD = 1500,
  parameter int MIN_PAYLOAD = 46,
  parameter int IFG_CLKS    = 12
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_pl_valid,
  input  logic [7:0]  i_pl_data,
  input  logic        i_pl_last,
  output logic        o_pl_ready,
  input  logic [47:0] i_dst_mac,
  input  logic [47:0] i_src_mac,
  input  logic [15:0] i_ethertype,
  input  logic [15:0] i_vlan_tci,
  output logic        o_tx_trig,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_last,
  input  logic        i_tx_over,
  output logic        o_busy,
  output logic        o_trunc
);

  localparam int CW = 11;
`ifdef ETH_TX_VLAN_EN
  localparam int HDR_LEN = 18;
  localparam int PAD_MIN = MIN_PAYLOAD - 4;
`else
  localparam int HDR_LEN = 14;
  localparam int PAD_MIN = MIN_PAYLOAD;
`endif
  localparam int HDR_W = HDR_LEN * 8;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_TRIG, S_HDR, S_PAY, S_PAD, S_WAIT, S_GAP
  } state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   len, len_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [CW-1:0]   rd_ptr, rd_ptr_nx;
  logic            trunc_seen, trunc_seen_nx;
  logic            wr_en, hdr_load, hdr_shift, producing;
  logic            trig_nx, last_nx, trunc_nx, ready_nx, busy_nx;
  logic [7:0]      data_nx;
  logic [CW-1:0]   pay_total, last_idx, pay_end;
  logic            accept;

  logic [7:0]      mem [MAX_PAYLOAD];
  logic [7:0]      rd_byte_p1;
  logic [HDR_W-1:0] hdr_q;
  logic [HDR_W-1:0] hdr_in;

`ifdef ETH_TX_VLAN_EN
  assign hdr_in = {i_dst_mac, i_src_mac, 16'h8100, i_vlan_tci, i_ethertype};
`else
  logic unused_tci;
  assign unused_tci = ^i_vlan_tci;
  assign hdr_in     = {i_dst_mac, i_src_mac, i_ethertype};
`endif

  assign accept    = i_pl_valid & o_pl_ready;
  assign pay_total = (len > CW'(PAD_MIN)) ? len : CW'(PAD_MIN);
  assign last_idx  = CW'(HDR_LEN) + pay_total - CW'(1);
  assign pay_end   = CW'(HDR_LEN) + len - CW'(1);
  assign producing = (state == S_TRIG) || (state == S_HDR) ||
                     (state == S_PAY)  || (state == S_PAD);

  always_comb begin
    state_nx      = state;
    len_nx        = len;
    cnt_nx        = cnt;
    rd_ptr_nx     = rd_ptr;
    trunc_seen_nx = trunc_seen;
    wr_en         = 1'b0;
    hdr_load      = 1'b0;
    hdr_shift     = 1'b0;
    trunc_nx      = 1'b0;
    data_nx       = 8'h00;
    case (state)
      S_IDLE: begin
        cnt_nx        = '0;
        rd_ptr_nx     = '0;
        trunc_seen_nx = 1'b0;
        if (accept) begin
          wr_en    = 1'b1;
          hdr_load = 1'b1;
          len_nx   = CW'(1);
          state_nx = i_pl_last ? S_TRIG : S_LOAD;
        end
      end
      S_LOAD: begin
        if (accept) begin
          if (len < CW'(MAX_PAYLOAD)) begin
            wr_en  = 1'b1;
            len_nx = len + CW'(1);
          end else if (!trunc_seen) begin
            trunc_nx      = 1'b1;
            trunc_seen_nx = 1'b1;
          end
          if (i_pl_last) state_nx = S_TRIG;
        end
      end
      // TRIG already produces PDU byte 0; its register stage puts it on the bus one clock later.
      S_TRIG: begin
        data_nx   = hdr_q[HDR_W-1 -: 8];
        hdr_shift = 1'b1;
        cnt_nx    = cnt + CW'(1);
        state_nx  = S_HDR;
      end
      S_HDR: begin
        data_nx   = hdr_q[HDR_W-1 -: 8];
        hdr_shift = 1'b1;
        cnt_nx    = cnt + CW'(1);
        if (cnt == CW'(HDR_LEN - 1)) begin
          rd_ptr_nx = rd_ptr + CW'(1);
          state_nx  = (len != '0) ? S_PAY : S_PAD;
        end
      end
      S_PAY: begin
        data_nx = rd_byte_p1;
        cnt_nx  = cnt + CW'(1);
        if (rd_ptr < CW'(MAX_PAYLOAD)) rd_ptr_nx = rd_ptr + CW'(1);
        if (cnt == last_idx)     state_nx = S_WAIT;
        else if (cnt == pay_end) state_nx = S_PAD;
      end
      S_PAD: begin
        cnt_nx = cnt + CW'(1);
        if (cnt == last_idx) state_nx = S_WAIT;
      end
      S_WAIT: begin
        cnt_nx = '0;
        if (i_tx_over) state_nx = S_GAP;
      end
      S_GAP: begin
        cnt_nx = cnt + CW'(1);
        if (cnt == CW'(IFG_CLKS - 1)) begin
          state_nx = S_IDLE;
          len_nx   = '0;
        end
      end
      default: state_nx = S_IDLE;
    endcase
    last_nx  = producing && (cnt == last_idx);
    trig_nx  = (state_nx == S_TRIG) || producing;
    ready_nx = (state_nx == S_IDLE) || (state_nx == S_LOAD);
    busy_nx  = (state_nx != S_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= S_IDLE;
      len        <= '0;
      cnt        <= '0;
      rd_ptr     <= '0;
      trunc_seen <= 1'b0;
      o_pl_ready <= 1'b1;
      o_busy     <= 1'b0;
      o_tx_trig  <= 1'b0;
      o_tx_data  <= 8'h00;
      o_tx_last  <= 1'b0;
      o_trunc    <= 1'b0;
    end else begin
      state      <= state_nx;
      len        <= len_nx;
      cnt        <= cnt_nx;
      rd_ptr     <= rd_ptr_nx;
      trunc_seen <= trunc_seen_nx;
      o_pl_ready <= ready_nx;
      o_busy     <= busy_nx;
      o_tx_trig  <= trig_nx;
      o_tx_data  <= data_nx;
      o_tx_last  <= last_nx;
      o_trunc    <= trunc_nx;
    end
  end

  // Payload buffer: one-clock read, prefetched during the last header byte.
  always_ff @(posedge i_clk) begin
    if (wr_en) mem[len] <= i_pl_data;
    if (rd_ptr < CW'(MAX_PAYLOAD)) rd_byte_p1 <= mem[rd_ptr];
    if (hdr_load)       hdr_q <= hdr_in;
    else if (hdr_shift) hdr_q <= {hdr_q[HDR_W-9:0], 8'h00};
  end

endmodule

// File: tb/tb_eth_tx_framer.sv
// Scoreboard bench for eth_tx_framer: a frame model queues expected PDU bytes, a monitor pops them.
module tb_eth_tx_framer;

  localparam int MAXP = 1500;
  localparam int MINP = 46;
  localparam int IFG  = 12;
`ifdef ETH_TX_VLAN_EN
  localparam int PADT = MINP - 4;
`else
  localparam int PADT = MINP;
`endif

  logic        clk = 1'b0;
  logic        i_rst, i_pl_valid, i_pl_last, i_tx_over;
  logic [7:0]  i_pl_data;
  logic [47:0] i_dst_mac, i_src_mac;
  logic [15:0] i_ethertype, i_vlan_tci;
  logic        o_pl_ready, o_tx_trig, o_tx_last, o_busy, o_trunc;
  logic [7:0]  o_tx_data;

  always #5 clk = ~clk;

  eth_tx_framer #(.MAX_PAYLOAD(MAXP), .MIN_PAYLOAD(MINP), .IFG_CLKS(IFG)) dut (
    .i_clk(clk), .i_rst(i_rst),
    .i_pl_valid(i_pl_valid), .i_pl_data(i_pl_data), .i_pl_last(i_pl_last),
    .o_pl_ready(o_pl_ready),
    .i_dst_mac(i_dst_mac), .i_src_mac(i_src_mac), .i_ethertype(i_ethertype),
    .i_vlan_tci(i_vlan_tci),
    .o_tx_trig(o_tx_trig), .o_tx_data(o_tx_data), .o_tx_last(o_tx_last),
    .i_tx_over(i_tx_over), .o_busy(o_busy), .o_trunc(o_trunc)
  );

  int errors = 0;
  int checks = 0;
  logic [8:0] exp_q[$];
  logic [7:0] pl[$];
  int nbytes = 0;
  int trunc_cnt = 0;
  logic trig_prev = 1'b0;
  logic last_prev = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference frame: header fields, payload clipped to MAXP, zero pad to the minimum.
  function automatic void build_expected(input logic [47:0] dst, input logic [47:0] src,
                                         input logic [15:0] et, input logic [15:0] tci);
    int plen;
    logic [8:0] b;
    for (int i = 0; i < 6; i++) exp_q.push_back({1'b0, dst[47-8*i -: 8]});
    for (int i = 0; i < 6; i++) exp_q.push_back({1'b0, src[47-8*i -: 8]});
`ifdef ETH_TX_VLAN_EN
    exp_q.push_back(9'h081);
    exp_q.push_back(9'h000);
    exp_q.push_back({1'b0, tci[15:8]});
    exp_q.push_back({1'b0, tci[7:0]});
`else
    if (tci == 16'hFFFF) plen = 0;
`endif
    exp_q.push_back({1'b0, et[15:8]});
    exp_q.push_back({1'b0, et[7:0]});
    plen = (pl.size() > MAXP) ? MAXP : pl.size();
    for (int i = 0; i < plen; i++) exp_q.push_back({1'b0, pl[i]});
    for (int i = plen; i < PADT; i++) exp_q.push_back(9'h000);
    b = exp_q.pop_back();
    exp_q.push_back({1'b1, b[7:0]});
  endfunction

  // Monitor: every clock with trig high after the trigger clock carries one PDU byte.
  always @(negedge clk) begin
    logic [8:0] e;
    if (o_tx_trig && trig_prev) begin
      if (exp_q.size() == 0) chk("tx_byte_unexpected", {o_tx_last, o_tx_data}, 9'h1FF);
      else begin
        e = exp_q.pop_front();
        chk("tx_byte", {55'd0, o_tx_last, o_tx_data}, {55'd0, e});
        nbytes++;
      end
    end else if (o_tx_last) chk("stray_last", o_tx_last, 1'b0);
    if (last_prev) chk("trig_fall", o_tx_trig, 1'b0);
    if (o_trunc) trunc_cnt++;
    trig_prev = o_tx_trig;
    last_prev = o_tx_last;
  end

  // MAC model: stray i_tx_over mid-frame, real i_tx_over after the last byte, then IFG timing.
  initial begin
    logic bad;
    i_tx_over = 1'b0;
    forever begin
      @(negedge clk);
      while (!o_tx_trig) @(negedge clk);
      repeat (3) @(negedge clk);
      i_tx_over = 1'b1;
      @(negedge clk);
      i_tx_over = 1'b0;
      while (o_tx_trig && !o_tx_last) @(negedge clk);
      if (o_tx_last) begin
        repeat ($urandom_range(1, 4)) @(negedge clk);
        i_tx_over = 1'b1;
        @(negedge clk);
        i_tx_over = 1'b0;
        bad = !o_busy || o_tx_trig || o_pl_ready;
        repeat (IFG - 1) begin
          @(negedge clk);
          if (!o_busy || o_tx_trig || o_pl_ready) bad = 1'b1;
        end
        chk("gap_hold", bad, 1'b0);
        @(negedge clk);
        chk("busy_release", {o_busy, o_pl_ready}, 2'b01);
      end
    end
  end

  task automatic send_frame(input logic [47:0] dst, input logic [47:0] src,
                            input logic [15:0] et, input logic [15:0] tci, input bit abort);
    int w;
    nbytes    = 0;
    trunc_cnt = 0;
    build_expected(dst, src, et, tci);
    for (int i = 0; i < pl.size(); i++) begin
      if ($urandom_range(0, 3) == 0) begin
        i_pl_valid = 1'b0;
        @(posedge clk); #1;
      end
      i_pl_valid  = 1'b1;
      i_pl_data   = pl[i];
      i_pl_last   = (i == pl.size() - 1);
      i_dst_mac   = (i == 0) ? dst : {$urandom, $urandom} ;
      i_src_mac   = (i == 0) ? src : {$urandom, $urandom};
      i_ethertype = (i == 0) ? et  : 16'($urandom);
      i_vlan_tci  = (i == 0) ? tci : 16'($urandom);
      w = 0;
      while (!o_pl_ready && w < 100) begin
        @(posedge clk); #1;
        w++;
      end
      if (!o_pl_ready) begin
        chk("pl_ready_timeout", o_pl_ready, 1'b1);
        break;
      end
      @(posedge clk); #1;
    end
    i_pl_valid = 1'b0;
    i_pl_last  = 1'b0;
    chk("ready_after_last", {o_pl_ready, o_busy}, 2'b01);
    if (abort) begin
      w = 0;
      while (nbytes < 21 && w < 4000) begin
        @(negedge clk); #1;
        w++;
      end
      chk("abort_reach_byte20", nbytes, 21);
      i_rst = 1'b1;
      @(posedge clk); #1;
      i_rst = 1'b0;
      @(negedge clk);
      chk("abort_state", {o_tx_trig, o_busy, o_pl_ready, o_tx_last, o_trunc}, 5'b00100);
      exp_q.delete();
    end else begin
      w = 0;
      while (o_busy && w < 6000) begin
        @(negedge clk);
        w++;
      end
      chk("frame_done", o_busy, 1'b0);
      chk("frame_bytes_left", exp_q.size(), 0);
      chk("trunc_pulses", trunc_cnt, (pl.size() > MAXP) ? 1 : 0);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic fill_random(input int n);
    pl.delete();
    for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
  endtask

  initial begin
    int n;
    i_rst = 1'b1;
    i_pl_valid = 1'b0; i_pl_data = 8'h00; i_pl_last = 1'b0;
    i_dst_mac = '0; i_src_mac = '0; i_ethertype = '0; i_vlan_tci = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {o_pl_ready, o_busy, o_tx_trig, o_tx_last, o_trunc, o_tx_data},
        {5'b10000, 8'h00});
    @(posedge clk); #1;
    i_rst = 1'b0;

    fill_random(100);
    send_frame(48'hAABBCCDDEEFF, 48'h021122334455, 16'h0800, 16'h0ABC, 1'b0);
    pl.delete(); pl.push_back(8'h5A);
    send_frame({$urandom, $urandom}, {$urandom, $urandom}, 16'h86DD, 16'h0001, 1'b0);
    fill_random(46);
    send_frame({$urandom, $urandom}, {$urandom, $urandom}, 16'h0806, 16'h0002, 1'b0);
    fill_random(1600);
    send_frame({$urandom, $urandom}, {$urandom, $urandom}, 16'h0800, 16'h0003, 1'b0);
    fill_random(80);
    send_frame({$urandom, $urandom}, {$urandom, $urandom}, 16'h0800, 16'h0004, 1'b1);
    fill_random(30);
    send_frame(48'h112233445566, 48'h778899AABBCC, 16'h88B5, 16'h0005, 1'b0);
`ifdef ETH_TX_VLAN_EN
    fill_random(10);
    send_frame({$urandom, $urandom}, {$urandom, $urandom}, 16'h0800, 16'h0123, 1'b0);
`endif
    foreach (pl[i]) pl[i] = 8'h00;
    repeat (8) begin
      n = $urandom_range(1, 120);
      fill_random(n);
      send_frame({$urandom, $urandom}, {$urandom, $urandom}, 16'($urandom), 16'($urandom), 1'b0);
    end
    fill_random(45);
    send_frame({$urandom, $urandom}, {$urandom, $urandom}, 16'h0800, 16'h0010, 1'b0);
    fill_random(47);
    send_frame({$urandom, $urandom}, {$urandom, $urandom}, 16'h0800, 16'h0011, 1'b0);
    fill_random(1500);
    send_frame({$urandom, $urandom}, {$urandom, $urandom}, 16'h0800, 16'h0012, 1'b0);
    fill_random(1501);
    send_frame({$urandom, $urandom}, {$urandom, $urandom}, 16'h0800, 16'h0013, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
